// File: rtl/dmem_responder.sv
// Word-organised data-memory responder: one request at a time, programmable wait states, byte/half/word lanes.
// Optional macro DMEM_STRICT_ALIGN_EN rejects misaligned halfword/word accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_WAIT   = 1,
    parameter int WRITE_WAIT  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic [1:0]  byte_size,
    output logic [31:0] mem_data_in,
    output logic        mem_read_ready,
    output logic        mem_write_ready,
    output logic        mem_err
);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rrdy_q, rrdy_d;
    logic        wrdy_q, wrdy_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] rd_word, rd_lane, wr_word, wsrc, byte_sh;
    logic [3:0]  be;
    logic        bad, align_err, mem_we;

    assign idx     = addr_q[AW+1:2];
    assign rd_word = mem_q[idx];
    assign byte_sh = rd_word >> {addr_q[1:0], 3'b000};

`ifdef DMEM_STRICT_ALIGN_EN
    assign align_err = ((size_q == 2'd2) && addr_q[0]) || ((size_q == 2'd0) && (addr_q[1:0] != 2'd0));
`else
    assign align_err = 1'b0;
`endif
    assign bad = (addr_q[31:2] >= DEPTH_IDX) || (size_q == 2'd3) || align_err;

    // Lane extraction and read-modify-write merge for the latched request
    always_comb begin
        rd_lane = rd_word;
        be      = 4'h0;
        wsrc    = wdata_q;
        case (size_q)
            2'd0: begin
                rd_lane = rd_word;
                be      = 4'hF;
            end
            2'd1: begin
                rd_lane = {24'h0, byte_sh[7:0]};
                be      = 4'b0001 << addr_q[1:0];
                wsrc    = {4{wdata_q[7:0]}};
            end
            2'd2: begin
                rd_lane = addr_q[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
                be      = addr_q[1] ? 4'b1100 : 4'b0011;
                wsrc    = {2{wdata_q[15:0]}};
            end
            default: begin
                rd_lane = 32'h0;
                be      = 4'h0;
            end
        endcase
        for (int b = 0; b < 4; b++)
            wr_word[8*b +: 8] = be[b] ? wsrc[8*b +: 8] : rd_word[8*b +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        rrdy_d  = 1'b0;
        wrdy_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read_en) begin
                    addr_d  = mem_addr;
                    size_d  = byte_size;
                    is_wr_d = 1'b0;
                    cnt_d   = 4'(READ_WAIT);
                    state_d = WAIT;
                end else if (mem_write_en) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_data;
                    size_d  = byte_size;
                    is_wr_d = 1'b1;
                    cnt_d   = 4'(WRITE_WAIT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ACK;
                    rrdy_d  = ~is_wr_q;
                    wrdy_d  = is_wr_q;
                    if (bad) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (is_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = rd_lane;
                    end
                end
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'h0;
            rrdy_q  <= 1'b0;
            wrdy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            rrdy_q  <= rrdy_d;
            wrdy_q  <= wrdy_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a write only commits on the WAIT->ACK edge
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[idx] <= wr_word;
    end

    assign mem_data_in     = rdata_q;
    assign mem_read_ready  = rrdy_q;
    assign mem_write_ready = wrdy_q;
    assign mem_err         = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, lanes, arbitration, range/size errors, reset mid-write.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_en = 1'b0, mem_write_en = 1'b0;
    logic [31:0] mem_addr = 32'h0, mem_data = 32'h0;
    logic [1:0]  byte_size = 2'd0;
    logic [31:0] d0, d3;
    logic        rr0, wr0, er0, rr3, wr3, er3;
    logic        sel = 1'b0;
    logic [31:0] rdata;
    logic        rrdy, wrdy, err;
    int          n_chk = 0, n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .READ_WAIT(1), .WRITE_WAIT(0)) dut (
        .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .byte_size(byte_size),
        .mem_data_in(d0), .mem_read_ready(rr0), .mem_write_ready(wr0), .mem_err(er0));

    dmem_responder #(.DEPTH_WORDS(1024), .READ_WAIT(1), .WRITE_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data(mem_data), .byte_size(byte_size),
        .mem_data_in(d3), .mem_read_ready(rr3), .mem_write_ready(wr3), .mem_err(er3));

    always_comb begin
        rdata = sel ? d3  : d0;
        rrdy  = sel ? rr3 : rr0;
        wrdy  = sel ? wr3 : wr0;
        err   = sel ? er3 : er0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE; returns data/err at the ready cycle and edges-to-ready.
    task automatic req(input logic rd, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, output logic [31:0] rd_out,
                       output logic er_out, output int lat);
        logic seen;
        @(negedge clk);
        mem_read_en = rd; mem_write_en = ~rd;
        mem_addr = a; mem_data = d; byte_size = sz;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (rd ? rrdy : wrdy) seen = 1'b1;
        end
        if (!seen) chk("req_timeout", {31'h0, seen}, 32'h1);
        rd_out = rdata; er_out = err;
        @(posedge clk); #1;
        chk("ready_single_pulse", {31'h0, rrdy | wrdy}, 32'h0);
        mem_read_en = 1'b0; mem_write_en = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] v;
    logic        e;
    int          lat, gap;
    logic        seen;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", d0, 32'h0);
        chk("rst_rrdy", {31'h0, rr0}, 32'h0);
        chk("rst_wrdy", {31'h0, wr0}, 32'h0);
        chk("rst_err",  {31'h0, er0}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // word write / read latency
        req(1'b0, 32'h10, 32'h12345678, 2'd0, v, e, lat);
        chk("sw_lat", lat, 2);
        req(1'b1, 32'h10, 32'h0, 2'd0, v, e, lat);
        chk("lw_lat", lat, 3);
        chk("lw_data", v, 32'h12345678);
        chk("lw_err", {31'h0, e}, 32'h0);

        // byte lanes
        req(1'b0, 32'h20, 32'hAABBCCDD, 2'd0, v, e, lat);
        req(1'b0, 32'h22, 32'hFFFFFF11, 2'd1, v, e, lat);
        req(1'b1, 32'h20, 32'h0, 2'd0, v, e, lat);
        chk("sb_merge", v, 32'hAA11CCDD);
        req(1'b1, 32'h23, 32'h0, 2'd1, v, e, lat);
        chk("lb_23", v, 32'h000000AA);
        req(1'b1, 32'h22, 32'h0, 2'd2, v, e, lat);
        chk("lh_22", v, 32'h0000AA11);
        req(1'b1, 32'h20, 32'h0, 2'd1, v, e, lat);
        chk("lb_20", v, 32'h000000DD);

        // misaligned halfword
        req(1'b1, 32'h21, 32'h0, 2'd2, v, e, lat);
`ifdef DMEM_STRICT_ALIGN_EN
        chk("lh_21_data", v, 32'h0);
        chk("lh_21_err", {31'h0, e}, 32'h1);
`else
        chk("lh_21_data", v, 32'h0000CCDD);
        chk("lh_21_err", {31'h0, e}, 32'h0);
`endif

        // reserved size
        req(1'b1, 32'h10, 32'h0, 2'd1, v, e, lat);
        req(1'b1, 32'h10, 32'h0, 2'd3, v, e, lat);
        chk("size3_data", v, 32'h0);
        chk("size3_err", {31'h0, e}, 32'h1);

        // simultaneous read and write: read wins, write follows 4 cycles later
        req(1'b0, 32'h30, 32'h01010101, 2'd0, v, e, lat);
        @(negedge clk);
        mem_read_en = 1'b1; mem_write_en = 1'b1;
        mem_addr = 32'h30; mem_data = 32'hCAFEF00D; byte_size = 2'd0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1; lat++;
            if (rr0) seen = 1'b1;
        end
        chk("both_rd_lat", lat, 3);
        chk("both_rd_data", d0, 32'h01010101);
        chk("both_no_wr_yet", {31'h0, wr0}, 32'h0);
        @(posedge clk); #1;
        mem_read_en = 1'b0;
        gap = 1; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (wr0) seen = 1'b1;
            else begin @(posedge clk); #1; gap++; end
        end
        chk("both_ack_spacing", gap, 4);
        @(posedge clk); #1;
        mem_write_en = 1'b0;
        @(posedge clk); #1;
        req(1'b1, 32'h30, 32'h0, 2'd0, v, e, lat);
        chk("both_readback", v, 32'hCAFEF00D);

        // out-of-range
        req(1'b0, 32'h0, 32'h55AA55AA, 2'd0, v, e, lat);
        req(1'b1, 32'h0, 32'h0, 2'd0, v, e, lat);
        req(1'b1, 32'h1000, 32'h0, 2'd0, v, e, lat);
        chk("oor_rd_lat", lat, 3);
        chk("oor_rd_data", v, 32'h0);
        chk("oor_rd_err", {31'h0, e}, 32'h1);
        req(1'b0, 32'h1000, 32'hDEADBEEF, 2'd0, v, e, lat);
        chk("oor_wr_err", {31'h0, e}, 32'h1);
        req(1'b1, 32'h0, 32'h0, 2'd0, v, e, lat);
        chk("oor_word0_kept", v, 32'h55AA55AA);
        chk("oor_word0_err", {31'h0, e}, 32'h0);

        // reset during a WRITE_WAIT=3 write
        sel = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req(1'b0, 32'h40, 32'h11112222, 2'd0, v, e, lat);
        chk("w3_lat", lat, 5);
        req(1'b1, 32'h40, 32'h0, 2'd0, v, e, lat);
        chk("w3_rd_data", v, 32'h11112222);
        @(negedge clk);
        mem_write_en = 1'b1; mem_addr = 32'h40; mem_data = 32'h99998888; byte_size = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_data", d3, 32'h0);
        chk("mid_rst_rdy", {30'h0, rr3, wr3}, 32'h0);
        chk("mid_rst_err", {31'h0, er3}, 32'h0);
        @(negedge clk);
        mem_write_en = 1'b0; rst = 1'b0;
        req(1'b1, 32'h40, 32'h0, 2'd0, v, e, lat);
        chk("mid_rst_not_committed", v, 32'h11112222);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that answers the load/store request interface driven by the execute-stage memory unit. It accepts one read or write request at a time and applies configurable wait states. It performs byte, halfword or word access into an internal word-organised SRAM array. It returns right-justified read data, zero-filled above the accessed width, with a one-cycle ready pulse, and flags misaligned or out-of-range accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; word index = mem_addr[31:2].
READ_WAIT, 1, extra wait cycles before a read is acknowledged (0..15).
WRITE_WAIT, 0, extra wait cycles before a write is acknowledged (0..15).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
mem_read_en  in  1  read request; held high by the requester until it samples mem_read_ready.
mem_write_en  in  1  write request; held high until mem_write_ready is sampled.
mem_addr  in  32  byte address.
mem_data  in  32  write data, right-justified.
byte_size  in  2  access size: 0 = word, 1 = byte, 2 = halfword, 3 = reserved.
mem_data_in  out  32  read data to requester, right-justified, zero above the access width.
mem_read_ready  out  1  one-cycle read acknowledge.
mem_write_ready  out  1  one-cycle write acknowledge.
mem_err  out  1  pulses together with the ready pulse when the access was rejected.

Behaviour:
- Reset values: mem_data_in = 0, mem_read_ready = 0, mem_write_ready = 0, mem_err = 0, state = IDLE, wait counter = 0. The array is not cleared.
- States are IDLE, WAIT, ACK and GAP.
- IDLE:
  - If mem_read_en = 1, latch addr and size, load the counter with READ_WAIT, and go to WAIT.
  - Otherwise, if mem_write_en = 1, latch addr, data and size, load WRITE_WAIT, and go to WAIT.
  - If both are high, the read wins. The write stays pending and is taken on a later IDLE.
- WAIT:
  - While counter ≠ 0, decrement it.
  - When counter = 0, perform the access at this edge, drive the matching ready = 1 and go to ACK.
- ACK:
  - The ready pulse (and mem_err if applicable) is high for exactly this one cycle.
  - On the next edge, ready and err return to 0 and the state goes to GAP.
- GAP: one cycle in which request inputs are ignored. This lets the requester drop its enable. Then go to IDLE.
- Latency: a request sampled at edge T0 gives ready high in the cycle after edge T0+1+WAIT. With WAIT = 0 that is the cycle after edge T0+1, giving 2-cycle request-to-ready. Back-to-back throughput is one access per WAIT+4 cycles.
- Read lanes:
  - Byte returns array[idx] byte addr[1:0] in bits [7:0].
  - Halfword returns the half selected by addr[1] in bits [15:0].
  - Word returns the whole word.
  - All upper bits are 0; sign extension is the requester's job.
- Write lanes:
  - Byte writes mem_data[7:0] into lane addr[1:0].
  - Halfword writes mem_data[15:0] into the half selected by addr[1].
  - Word writes all 32 bits. Other lanes are preserved.
- Errors: word index ≥ DEPTH_WORDS, or byte_size = 3, means no array access, mem_data_in = 0, and mem_err = 1 with the ready pulse. The request is still acknowledged.
- mem_data_in holds its last value outside ACK.
- Reset mid-operation: asynchronously returns to IDLE with outputs at reset values. A write still in WAIT is not committed. A write is committed only at the WAIT→ACK edge.
- Requests arriving during WAIT, ACK or GAP are not latched. The requester must keep enables asserted.

Optional Feature:
DMEM_STRICT_ALIGN_EN:
- Defined: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0, is rejected like an error. There is no access, data = 0 and mem_err = 1 with ready.
- Undefined: misalignment is not checked. Word accesses ignore addr[1:0]. Halfword accesses ignore addr[0]. mem_err reports only range and size errors.

Test Plan:
- Word write then read, READ_WAIT = 1 and WRITE_WAIT = 0:
  - Write 0x12345678 @0x10 gives mem_write_ready 2 cycles after the request edge.
  - Read @0x10 gives 0x12345678, with ready 3 cycles after the request edge, each as a single-cycle pulse.
- Byte lanes:
  - Word 0xAABBCCDD @0x20, then sb 0x11 @0x22, gives word 0xAA11CCDD.
  - lb @0x23 returns 0x000000AA.
  - lh @0x22 returns 0x0000AA11.
- Simultaneous mem_read_en and mem_write_en: the read is acknowledged first. The write is acknowledged afterwards, with 4+WAIT cycle spacing between acks, and a read-back shows the write landed after.
- Out-of-range @ DEPTH_WORDS*4: mem_read_ready and mem_err both 1 for one cycle, mem_data_in = 0. A write to that address leaves word 0 unchanged.
- Assert rst during a WRITE_WAIT = 3 write in WAIT: outputs go to 0 immediately, and a read-back of the target returns the old value.
- Misaligned halfword @0x21:
  - With DMEM_STRICT_ALIGN_EN: mem_err = 1 and data 0.
  - Without it: data equals the half @0x20, mem_err = 0.
